wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_ctrl.sv | 148 ++++++++++++++
 tb/tb_wb_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// Writeback-stage controller.
// Registers the writeback mux select, register-file write address and write
// enable. Non-load instructions write one cycle after entry. Loads park the
// FSM in LOAD_WAIT, stalling the pipeline, until the data-memory response
// arrives or the wait counter hits the timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | accepting instructions; non-loads write on the next edge
// LOAD_WAIT | load issued, waiting for load_valid_in; pipeline is stalled
module wb_ctrl #(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       instr_valid_in,
  input  logic [4:0] rd_addr_in,
  input  logic [2:0] wb_sel_in,
  input  logic       rf_wr_req_in,
  input  logic       is_load_in,
  input  logic       load_valid_in,
  input  logic       flush_in,
  output logic [2:0] wb_mux_sel_reg_out,
  output logic [4:0] rd_addr_reg_out,
  output logic       rf_wr_en_out,
  output logic       stall_out,
  output logic       illegal_sel_out,
  output logic       load_timeout_out
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] SEL_ALU    = 3'b000;
  localparam logic [2:0] SEL_LOAD   = 3'b001;
  localparam logic [2:0] SEL_IMM    = 3'b010;
  localparam logic [2:0] SEL_IADDER = 3'b011;
  localparam logic [2:0] SEL_PC4    = 3'b101;

  // The counter starts at 0 on load entry; matching LOAD_TIMEOUT-1 on a
  // non-response cycle means that cycle was the LOAD_TIMEOUT-th wait cycle.
  localparam logic [3:0] CNT_LAST = 4'(LOAD_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [4:0] ld_rd, ld_rd_nxt;
  logic [2:0] sel_nxt;
  logic [4:0] rd_nxt;
  logic       wr_en_nxt;
  logic       illegal_nxt;
  logic       timeout_nxt;
  logic       sel_legal;

  // Decode which writeback source codes the mux actually supports.
  always_comb begin
    sel_legal = 1'b0;
    case (wb_sel_in)
      SEL_ALU, SEL_LOAD, SEL_IMM, SEL_IADDER, SEL_PC4: sel_legal = 1'b1;
      default:                                         sel_legal = 1'b0;
    endcase
  end

  // Stall only while genuinely waiting; a response or a flush releases the
  // pipeline in the same cycle, and reset forces it low.
  assign stall_out = !rst_in && (state == LOAD_WAIT) && !load_valid_in && !flush_in;

  // Next-state and next-output logic; flush dominates everything but reset.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ld_rd_nxt   = ld_rd;
    sel_nxt     = wb_mux_sel_reg_out;
    rd_nxt      = rd_addr_reg_out;
    wr_en_nxt   = 1'b0;
    illegal_nxt = 1'b0;
    timeout_nxt = 1'b0;

    if (flush_in) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid_in) begin
            if (is_load_in) begin
              ld_rd_nxt = rd_addr_in;
              cnt_nxt   = 4'd0;
              state_nxt = LOAD_WAIT;
            end else if (sel_legal) begin
              sel_nxt   = wb_sel_in;
              rd_nxt    = rd_addr_in;
              wr_en_nxt = rf_wr_req_in && (rd_addr_in != 5'd0);
            end else begin
              sel_nxt     = SEL_ALU;
              rd_nxt      = rd_addr_in;
              illegal_nxt = 1'b1;
            end
          end
        end
        LOAD_WAIT: begin
          if (load_valid_in) begin
            sel_nxt   = SEL_LOAD;
            rd_nxt    = ld_rd;
            wr_en_nxt = (ld_rd != 5'd0);
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_nxt = 1'b1;
            cnt_nxt     = 4'd0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; reset wins over flush and response.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      ld_rd              <= 5'd0;
      wb_mux_sel_reg_out <= SEL_ALU;
      rd_addr_reg_out    <= 5'd0;
      rf_wr_en_out       <= 1'b0;
      illegal_sel_out    <= 1'b0;
      load_timeout_out   <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      ld_rd              <= ld_rd_nxt;
      wb_mux_sel_reg_out <= sel_nxt;
      rd_addr_reg_out    <= rd_nxt;
      rf_wr_en_out       <= wr_en_nxt;
      illegal_sel_out    <= illegal_nxt;
      load_timeout_out   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: inputs change 1 ns after the rising edge,
// registered outputs are checked 1 ns after the edge that updates them.
module tb_wb_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       instr_valid_in;
  logic [4:0] rd_addr_in;
  logic [2:0] wb_sel_in;
  logic       rf_wr_req_in;
  logic       is_load_in;
  logic       load_valid_in;
  logic       flush_in;
  logic [2:0] wb_mux_sel_reg_out;
  logic [4:0] rd_addr_reg_out;
  logic       rf_wr_en_out;
  logic       stall_out;
  logic       illegal_sel_out;
  logic       load_timeout_out;

  int checks = 0;
  int errors = 0;

  wb_ctrl #(.LOAD_TIMEOUT(15)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .instr_valid_in     (instr_valid_in),
    .rd_addr_in         (rd_addr_in),
    .wb_sel_in          (wb_sel_in),
    .rf_wr_req_in       (rf_wr_req_in),
    .is_load_in         (is_load_in),
    .load_valid_in      (load_valid_in),
    .flush_in           (flush_in),
    .wb_mux_sel_reg_out (wb_mux_sel_reg_out),
    .rd_addr_reg_out    (rd_addr_reg_out),
    .rf_wr_en_out       (rf_wr_en_out),
    .stall_out          (stall_out),
    .illegal_sel_out    (illegal_sel_out),
    .load_timeout_out   (load_timeout_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    instr_valid_in = 1'b0;
    is_load_in     = 1'b0;
    rf_wr_req_in   = 1'b0;
    load_valid_in  = 1'b0;
    flush_in       = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] sel,
                       input logic req, input logic ld);
    instr_valid_in = 1'b1;
    rd_addr_in     = rd;
    wb_sel_in      = sel;
    rf_wr_req_in   = req;
    is_load_in     = ld;
    load_valid_in  = 1'b0;
    flush_in       = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] sel, input logic [4:0] rd,
                          input logic wr, input logic ill, input logic tmo);
    chk({tag, "_sel"}, {5'd0, wb_mux_sel_reg_out}, {5'd0, sel});
    chk({tag, "_rd"},  {3'd0, rd_addr_reg_out},    {3'd0, rd});
    chk({tag, "_wr"},  {7'd0, rf_wr_en_out},       {7'd0, wr});
    chk({tag, "_ill"}, {7'd0, illegal_sel_out},    {7'd0, ill});
    chk({tag, "_tmo"}, {7'd0, load_timeout_out},   {7'd0, tmo});
  endtask

  initial begin
    rst_in     = 1'b1;
    rd_addr_in = 5'd0;
    wb_sel_in  = 3'b000;
    idle_in();
    #1;
    chk("stall_in_reset", {7'd0, stall_out}, 8'd0);
    tick();
    chk_outs("reset", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_in = 1'b0;

    // ALU op, rd=5
    issue(5'd5, 3'b000, 1'b1, 1'b0);
    #1 chk("alu_stall", {7'd0, stall_out}, 8'd0);
    tick();
    chk_outs("alu", 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
    idle_in();
    tick();
    chk("alu_pulse_end", {7'd0, rf_wr_en_out}, 8'd0);
    chk("alu_stall_after", {7'd0, stall_out}, 8'd0);

    // back-to-back non-loads, no bubbles
    issue(5'd1, 3'b010, 1'b1, 1'b0);
    tick();
    chk_outs("b2b_imm", 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
    issue(5'd2, 3'b011, 1'b1, 1'b0);
    tick();
    chk_outs("b2b_iadd", 3'b011, 5'd2, 1'b1, 1'b0, 1'b0);
    issue(5'd9, 3'b000, 1'b0, 1'b0);
    tick();
    chk_outs("no_wr_req", 3'b000, 5'd9, 1'b0, 1'b0, 1'b0);

    // write to x0 with pc+4
    issue(5'd0, 3'b101, 1'b1, 1'b0);
    tick();
    chk_outs("rd0_pc4", 3'b101, 5'd0, 1'b0, 1'b0, 1'b0);

    // illegal select
    issue(5'd3, 3'b110, 1'b1, 1'b0);
    tick();
    chk_outs("illegal", 3'b000, 5'd3, 1'b0, 1'b1, 1'b0);
    idle_in();
    tick();
    chk("illegal_pulse_end", {7'd0, illegal_sel_out}, 8'd0);

    // load rd=7, response after 3 stall cycles; instruction during wait ignored
    issue(5'd7, 3'b001, 1'b1, 1'b1);
    tick();
    chk("ld_entry_wr", {7'd0, rf_wr_en_out}, 8'd0);
    idle_in();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) issue(5'd12, 3'b010, 1'b1, 1'b0);
      else idle_in();
      #1 chk($sformatf("ld_stall_%0d", i), {7'd0, stall_out}, 8'd1);
      tick();
      chk($sformatf("ld_wait_wr_%0d", i), {7'd0, rf_wr_en_out}, 8'd0);
    end
    idle_in();
    load_valid_in = 1'b1;
    #1 chk("ld_resp_stall", {7'd0, stall_out}, 8'd0);
    tick();
    chk_outs("ld_resp", 3'b001, 5'd7, 1'b1, 1'b0, 1'b0);
    idle_in();
    tick();
    chk("ld_pulse_end", {7'd0, rf_wr_en_out}, 8'd0);
    chk("ld_idle_stall", {7'd0, stall_out}, 8'd0);

    // load timeout: 15 stall cycles then a single timeout pulse, no write
    issue(5'd4, 3'b001, 1'b1, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 15; i++) begin
      #1 chk($sformatf("tmo_stall_%0d", i), {7'd0, stall_out}, 8'd1);
      tick();
      if (i < 14) chk($sformatf("tmo_early_%0d", i), {7'd0, load_timeout_out}, 8'd0);
    end
    chk_outs("tmo", 3'b001, 5'd7, 1'b0, 1'b0, 1'b1);
    chk("tmo_idle_stall", {7'd0, stall_out}, 8'd0);
    tick();
    chk("tmo_pulse_end", {7'd0, load_timeout_out}, 8'd0);

    // flush together with load response
    issue(5'd6, 3'b001, 1'b1, 1'b1);
    tick();
    idle_in();
    tick();
    load_valid_in = 1'b1;
    flush_in      = 1'b1;
    #1 chk("flush_ld_stall", {7'd0, stall_out}, 8'd0);
    tick();
    idle_in();
    chk("flush_ld_wr", {7'd0, rf_wr_en_out}, 8'd0);
    chk("flush_ld_rd", {3'd0, rd_addr_reg_out}, 8'd7);
    #1 chk("flush_ld_idle", {7'd0, stall_out}, 8'd0);

    // flush drops the current IDLE instruction
    issue(5'd8, 3'b000, 1'b1, 1'b0);
    flush_in = 1'b1;
    tick();
    idle_in();
    chk("flush_idle_wr", {7'd0, rf_wr_en_out}, 8'd0);
    chk("flush_idle_rd", {3'd0, rd_addr_reg_out}, 8'd7);

    // reset in the middle of LOAD_WAIT, response in the same cycle
    issue(5'd10, 3'b001, 1'b1, 1'b1);
    tick();
    idle_in();
    tick();
    rst_in        = 1'b1;
    load_valid_in = 1'b1;
    #1 chk("rst_ld_stall", {7'd0, stall_out}, 8'd0);
    tick();
    chk_outs("rst_ld", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_in = 1'b0;
    idle_in();
    #1 chk("rst_ld_idle", {7'd0, stall_out}, 8'd0);
    tick();
    chk("rst_ld_nowr", {7'd0, rf_wr_en_out}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
